seven_seg_capture: RTL and testbench

- Receive-side model of the multiplexed 7-segment interface: watches the active-low anode and segment lines driven by a scan driver.
- Waits for each anode/segment combination to be stable, then stores the lit-segment pattern per digit and decodes it back to a hex nibble.
- Used as an on-chip loopback checker and LED monitor for display drivers, in the same clock domain as the driver.

---
 rtl/seven_seg_capture_if.sv | 43 ++++
 rtl/seven_seg_capture.sv | 193 +++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
// Pin-side bundle of the 7-segment capture block: active-low scan lines in, decoded display state out.
// SEVEN_SEG_CAPTURE_DP_EN adds the decimal-point line (seg_dp) and its captured per-digit flag (dp).
interface seven_seg_capture_if #(
    parameter int unsigned n_anodes = 8
) ();
    logic [n_anodes-1:0]   anodes;
    logic                  seg_a;
    logic                  seg_b;
    logic                  seg_c;
    logic                  seg_d;
    logic                  seg_e;
    logic                  seg_f;
    logic                  seg_g;
    logic                  err_clr;
    logic [7*n_anodes-1:0] pattern;
    logic [4*n_anodes-1:0] digits;
    logic [n_anodes-1:0]   digit_valid;
    logic                  update;
    logic                  frame_done;
    logic                  multi_err;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic                  seg_dp;
    logic [n_anodes-1:0]   dp;

    modport master (
        output anodes, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp, err_clr,
        input  pattern, digits, digit_valid, update, frame_done, multi_err, dp
    );
    modport slave (
        input  anodes, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp, err_clr,
        output pattern, digits, digit_valid, update, frame_done, multi_err, dp
    );
`else
    modport master (
        output anodes, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, err_clr,
        input  pattern, digits, digit_valid, update, frame_done, multi_err
    );
    modport slave (
        input  anodes, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, err_clr,
        output pattern, digits, digit_valid, update, frame_done, multi_err
    );
`endif
endinterface

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a multiplexed 7-segment scan: captures each stable digit and decodes it to hex.
// Optional macro SEVEN_SEG_CAPTURE_DP_EN adds the decimal-point input and per-digit dp capture.
module seven_seg_capture #(
    parameter int unsigned n_anodes      = 8,
    parameter int unsigned settle_cycles = 16,
    parameter int unsigned sync_stages   = 2
) (
    input logic                clk,
    input logic                reset,
    seven_seg_capture_if.slave bus
);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    localparam int unsigned DP_W = 1;
`else
    localparam int unsigned DP_W = 0;
`endif
    localparam int unsigned SEG_LSB = DP_W;
    localparam int unsigned SW      = n_anodes + 7 + DP_W;
    localparam int unsigned CW      = $clog2(settle_cycles);

    logic [SW-1:0] raw_s;
    logic [SW-1:0] samp;
    logic [SW-1:0] prev_q;

`ifdef SEVEN_SEG_CAPTURE_DP_EN
    assign raw_s = {bus.anodes, bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
                    bus.seg_e, bus.seg_f, bus.seg_g, bus.seg_dp};
`else
    assign raw_s = {bus.anodes, bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
                    bus.seg_e, bus.seg_f, bus.seg_g};
`endif

    // Input synchronizer; reset to the idle (all lines high) level
    generate
        if (sync_stages == 0) begin : g_direct
            assign samp = raw_s;
        end else begin : g_sync
            logic [SW-1:0] sync_q [sync_stages];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < int'(sync_stages); k++) sync_q[k] <= '1;
                end else begin
                    sync_q[0] <= raw_s;
                    for (int k = 1; k < int'(sync_stages); k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign samp = sync_q[sync_stages-1];
        end
    endgenerate

    logic [n_anodes-1:0] low;
    logic [6:0]          lit;
    logic                single;
    logic                multi;

    assign low    = ~samp[SW-1 -: n_anodes];
    assign lit    = ~samp[SEG_LSB +: 7];
    assign multi  = (low & (low - n_anodes'(1))) != '0;
    assign single = (low != '0) && !multi;

    // {legal glyph, nibble}
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h7E:   decode = 5'h10;
            7'h30:   decode = 5'h11;
            7'h6D:   decode = 5'h12;
            7'h79:   decode = 5'h13;
            7'h33:   decode = 5'h14;
            7'h5B:   decode = 5'h15;
            7'h5F:   decode = 5'h16;
            7'h70:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h7B:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h1F:   decode = 5'h1B;
            7'h4E:   decode = 5'h1C;
            7'h3D:   decode = 5'h1D;
            7'h4F:   decode = 5'h1E;
            7'h47:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [CW-1:0]         cnt_q,      cnt_d;
    logic                  captured_q, captured_d;
    logic [n_anodes-1:0]   seen_q,     seen_d;
    logic [n_anodes-1:0]   seen_nx;
    logic [7*n_anodes-1:0] pattern_q,  pattern_d;
    logic [4*n_anodes-1:0] digits_q,   digits_d;
    logic [n_anodes-1:0]   valid_q,    valid_d;
    logic                  update_q,   update_d;
    logic                  frame_q,    frame_d;
    logic                  err_q,      err_d;
    logic                  fire;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic [n_anodes-1:0]   dp_q,       dp_d;
`endif

    // Settle tracking and capture; fires on the edge that completes settle_cycles equal samples
    always_comb begin
        cnt_d      = cnt_q;
        captured_d = captured_q;
        seen_d     = seen_q;
        seen_nx    = seen_q;
        pattern_d  = pattern_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        update_d   = 1'b0;
        frame_d    = 1'b0;
        err_d      = bus.err_clr ? 1'b0 : err_q;
        fire       = 1'b0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        dp_d       = dp_q;
`endif
        if (samp != prev_q) begin
            cnt_d      = '0;
            captured_d = 1'b0;
        end else begin
            if (cnt_q != CW'(settle_cycles - 1)) cnt_d = cnt_q + CW'(1);
            if (!captured_q && (cnt_q == CW'(settle_cycles - 2))) begin
                captured_d = 1'b1;
                fire       = 1'b1;
            end
        end

        if (fire) begin
            if (single) begin
                for (int i = 0; i < int'(n_anodes); i++) begin
                    if (low[i]) begin
                        pattern_d[7*i +: 7]             = lit;
                        {valid_d[i], digits_d[4*i +: 4]} = decode(lit);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
                        dp_d[i]                         = ~samp[0];
`endif
                    end
                end
                update_d = 1'b1;
                seen_nx  = seen_q | low;
                if (&seen_nx) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d  = seen_nx;
                end
            end else if (multi) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '1;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            seen_q     <= '0;
            pattern_q  <= '0;
            digits_q   <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            dp_q       <= '0;
`endif
        end else begin
            prev_q     <= samp;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            seen_q     <= seen_d;
            pattern_q  <= pattern_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            dp_q       <= dp_d;
`endif
        end
    end

    assign bus.pattern     = pattern_q;
    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.update      = update_q;
    assign bus.frame_done  = frame_q;
    assign bus.multi_err   = err_q;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    assign bus.dp          = dp_q;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Randomized + directed bench for seven_seg_capture against a pin-history reference model.
module tb_seven_seg_capture;
    localparam int unsigned N      = 8;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned PW     = N + 7;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seven_seg_capture_if #(.n_anodes(N)) bus ();

    seven_seg_capture #(
        .n_anodes(N), .settle_cycles(SETTLE), .sync_stages(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: a pin value that stays put for SETTLE consecutive samples takes
    // effect SYNC edges later, once per stable run.
    logic [6:0] m_pat [N];
    logic [3:0] m_dig [N];
    logic [N-1:0] m_val, m_seen;
    logic m_upd, m_frame, m_err;
    int run;
    logic [PW-1:0] last;
    typedef struct { bit ev; logic [PW-1:0] p; } samp_t;
    samp_t dq [$];

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] nib;
            nib = 4'(k);
            if (glyph[k] == p) return {1'b1, nib};
        end
        return 5'h00;
    endfunction

    task automatic apply(input logic [PW-1:0] p);
        logic [N-1:0] lo;
        logic [6:0] pat;
        lo  = ~p[PW-1:7];
        pat = ~p[6:0];
        if ($countones(lo) == 1) begin
            for (int i = 0; i < int'(N); i++)
                if (lo[i]) begin
                    m_pat[i] = pat;
                    {m_val[i], m_dig[i]} = ref_decode(pat);
                end
            m_upd  = 1'b1;
            m_seen = m_seen | lo;
            if (m_seen == '1) begin
                m_frame = 1'b1;
                m_seen  = '0;
            end
        end else if ($countones(lo) > 1) begin
            m_err = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        logic [PW-1:0] pins;
        samp_t e;
        pins = {bus.anodes, bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g};
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin m_pat[i] = '0; m_dig[i] = '0; end
            m_val = '0; m_seen = '0; m_upd = 1'b0; m_frame = 1'b0; m_err = 1'b0;
            run = 0;
            dq.delete();
        end else begin
            m_upd   = 1'b0;
            m_frame = 1'b0;
            if (bus.err_clr) m_err = 1'b0;
            run  = (run > 0 && pins == last) ? run + 1 : 1;
            last = pins;
            e.ev = (run == int'(SETTLE));
            e.p  = pins;
            dq.push_back(e);
            if (dq.size() > int'(SYNC)) begin
                e = dq.pop_front();
                if (e.ev) apply(e.p);
            end
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        logic [7*N-1:0] ep;
        logic [4*N-1:0] ed;
        for (int i = 0; i < int'(N); i++) begin
            ep[7*i +: 7] = m_pat[i];
            ed[4*i +: 4] = m_dig[i];
        end
        check("pattern",     64'(bus.pattern),     64'(ep));
        check("digits",      64'(bus.digits),      64'(ed));
        check("digit_valid", 64'(bus.digit_valid), 64'(m_val));
        check("update",      64'(bus.update),      64'(m_upd));
        check("frame_done",  64'(bus.frame_done),  64'(m_frame));
        check("multi_err",   64'(bus.multi_err),   64'(m_err));
    end

    task automatic drive(input logic [N-1:0] a, input logic [6:0] s_n);
        @(negedge clk);
        bus.anodes = a;
        {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g} = s_n;
    endtask

    task automatic hold(input int n, output int ups, output int frs, output int first);
        ups = 0; frs = 0; first = -1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (bus.update) begin
                ups++;
                if (first < 0) first = k;
            end
            if (bus.frame_done) frs++;
        end
    endtask

    initial begin
        int ups, frs, first, acc, ftot;
        logic [N-1:0] a;
        logic [7*N-1:0] pat_lit;
        bus.anodes = '1;
        {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g} = 7'h7F;
        bus.err_clr = 1'b0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        bus.seg_dp = 1'b1;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pattern", 64'(bus.pattern), 64'(0));
        check("rst_digits",  64'(bus.digits), 64'(0));
        check("rst_valid",   64'(bus.digit_valid), 64'(0));
        check("rst_err",     64'(bus.multi_err), 64'(0));
        reset = 1'b0;

        // Digit 0 showing "0": first capture latency
        drive(8'hFE, 7'b0000001);
        hold(20, ups, frs, first);
        check("t1_updates", 64'(ups), 64'(1));
        check("t1_latency", 64'(first), 64'(SYNC + 16));
        check("t1_pattern", 64'(bus.pattern[6:0]), 64'(7'h7E));
        check("t1_digit",   64'(bus.digits[3:0]), 64'(0));
        check("t1_valid",   64'(bus.digit_valid[0]), 64'(1));

        // Full scan 1..8 completes a frame on digit 7
        ftot = 0;
        for (int d = 0; d < 8; d++) begin
            a = ~(8'(1) << d);
            drive(a, ~glyph[d+1]);
            hold(32, ups, frs, first);
            ftot += frs;
            if (d == 7) check("t2_frame_last", 64'(frs), 64'(1));
        end
        check("t2_frames", 64'(ftot), 64'(1));
        check("t2_digits", 64'(bus.digits), 64'(32'h87654321));
        check("t2_valid",  64'(bus.digit_valid), 64'(8'hFF));

        // Illegal glyph on digit 3
        drive(~8'h08, 7'b0111111);
        hold(40, ups, frs, first);
        check("t3_updates", 64'(ups), 64'(1));
        check("t3_valid",   64'(bus.digit_valid[3]), 64'(0));
        check("t3_digit",   64'(bus.digits[15:12]), 64'(0));

        // Two anodes low: error, no capture, then clear
        pat_lit = {7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h40, 7'h79, 7'h6D, 7'h30};
        drive(8'hFC, 7'b0000001);
        hold(20, ups, frs, first);
        check("t4_updates", 64'(ups), 64'(0));
        check("t4_err",     64'(bus.multi_err), 64'(1));
        check("t4_pattern", 64'(bus.pattern), 64'(pat_lit));
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        check("t4_err_clr", 64'(bus.multi_err), 64'(0));
        @(negedge clk);
        bus.err_clr = 1'b0;

        // Segment toggling faster than settle: nothing captured until it stops
        acc = 0;
        for (int t = 0; t < 6; t++) begin
            drive(8'hFE, (t % 2 == 0) ? 7'b1000000 : 7'b0000000);
            hold(9, ups, frs, first);
            acc += ups;
        end
        check("t5_no_update", 64'(acc), 64'(0));
        hold(20, ups, frs, first);
        check("t5_updates", 64'(ups), 64'(1));
        check("t5_digit",   64'(bus.digits[3:0]), 64'(8));

        // Reset mid-settle discards progress
        drive(8'hFD, ~glyph[2]);
        hold(13, ups, frs, first);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_pattern", 64'(bus.pattern), 64'(0));
        check("t6_rst_valid",   64'(bus.digit_valid), 64'(0));
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        hold(20, ups, frs, first);
        check("t6_updates", 64'(ups), 64'(1));
        check("t6_latency", 64'(first), 64'(SYNC + 16));

        // Randomized traffic
        for (int r = 0; r < 300; r++) begin
            int kind;
            logic [6:0] s;
            kind = $urandom_range(0, 9);
            s = ($urandom_range(0, 1) == 0) ? ~glyph[$urandom_range(0, 15)] : 7'($urandom);
            if (kind <= 5) begin
                a = ~(8'(1) << $urandom_range(0, N - 1));
            end else if (kind == 6) begin
                a = '1;
            end else if (kind == 7) begin
                a = 8'($urandom);
                a[0] = 1'b0;
                a[$urandom_range(1, N - 1)] = 1'b0;
            end else begin
                a = bus.anodes;
            end
            drive(a, s);
            bus.err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #1 reset = 1'b1;
                repeat (2) @(negedge clk);
                #1 reset = 1'b0;
            end
            hold($urandom_range(1, 40), ups, frs, first);
        end
        @(negedge clk);
        bus.err_clr = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
